// File: rtl/mem_access_unit.sv
// Load/store initiator for the ram valid/ready port: formats lanes, waits for read data, extends it.
// Response 2 cycles after accept for a store with immediate ready; req_ready_out low until the response cycle ends.
module mem_access_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_in,
  output logic                  req_ready_out,
  input  logic                  req_is_store_in,
  input  logic [2:0]            req_funct3_in,
  input  logic [ADDR_WIDTH-1:0] req_addr_in,
  input  logic [DATA_WIDTH-1:0] req_wdata_in,
  output logic [ADDR_WIDTH-1:0] ram_addr_out,
  output logic [DATA_WIDTH-1:0] ram_write_data_out,
  output logic                  ram_read_en_out,
  output logic                  ram_write_en_out,
  output logic [3:0]            ram_write_byte_en_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  input  logic                  rdata_valid_in,
  input  logic [DATA_WIDTH-1:0] ram_read_data_in,
  output logic                  resp_valid_out,
  output logic [DATA_WIDTH-1:0] resp_rdata_out,
  output logic [1:0]            resp_err_out
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_MIS = 2'b01;
  localparam logic [1:0] ERR_TO  = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

  state_e                state_q;
  logic                  req_ready_q;
  logic                  valid_q;
  logic                  rd_en_q;
  logic                  wr_en_q;
  logic [3:0]            be_q;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  resp_valid_q;
  logic [DATA_WIDTH-1:0] resp_rdata_q;
  logic [1:0]            resp_err_q;
  logic [CW-1:0]         cnt_q;
  logic [1:0]            off_q;
  logic [2:0]            funct3_q;
  logic                  is_store_q;

  logic                  misalign_d;
  logic [3:0]            be_d;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic [15:0]           lane_d;
  logic [DATA_WIDTH-1:0] load_d;

  // Request formatting from the live request inputs, consumed only on accept.
  always_comb begin
    misalign_d = 1'b0;
    be_d       = 4'b1111;
    wdata_d    = req_wdata_in;
    case (req_funct3_in)
      3'b000, 3'b100: begin
        be_d    = 4'b0001 << req_addr_in[1:0];
        wdata_d = {4{req_wdata_in[7:0]}};
      end
      3'b001, 3'b101: begin
        misalign_d = req_addr_in[0];
        be_d       = 4'b0011 << req_addr_in[1:0];
        wdata_d    = {2{req_wdata_in[15:0]}};
      end
      3'b010:  misalign_d = (req_addr_in[1:0] != 2'b00);
      default: misalign_d = 1'b1;
    endcase
  end

  // Halfword accesses are aligned, so shifting by the byte offset also selects half o[1].
  always_comb begin
    lane_d = 16'(ram_read_data_in >> {off_q, 3'b000});
    case (funct3_q)
      3'b000:  load_d = {{24{lane_d[7]}}, lane_d[7:0]};
      3'b100:  load_d = {24'b0, lane_d[7:0]};
      3'b001:  load_d = {{16{lane_d[15]}}, lane_d[15:0]};
      3'b101:  load_d = {16'b0, lane_d[15:0]};
      default: load_d = ram_read_data_in;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b1;
      valid_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      be_q         <= '0;
      ram_addr_q   <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= ERR_OK;
      cnt_q        <= '0;
      off_q        <= '0;
      funct3_q     <= '0;
      is_store_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_in) begin
            req_ready_q <= 1'b0;
            off_q       <= req_addr_in[1:0];
            funct3_q    <= req_funct3_in;
            is_store_q  <= req_is_store_in;
            if (misalign_d) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= '0;
              resp_err_q   <= ERR_MIS;
            end else begin
              state_q    <= S_REQ;
              valid_q    <= 1'b1;
              rd_en_q    <= ~req_is_store_in;
              wr_en_q    <= req_is_store_in;
              be_q       <= req_is_store_in ? be_d : 4'b1111;
              ram_addr_q <= {req_addr_in[ADDR_WIDTH-1:2], 2'b00};
              wdata_q    <= req_is_store_in ? wdata_d : '0;
              cnt_q      <= '0;
            end
          end
        end
        S_REQ: begin
          if (ready_in || cnt_q == CNT_LAST) begin
            valid_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            be_q       <= '0;
            ram_addr_q <= '0;
            wdata_q    <= '0;
          end
          if (ready_in) begin
            if (is_store_q) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= '0;
              resp_err_q   <= ERR_OK;
            end else if (rdata_valid_in) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= load_d;
              resp_err_q   <= ERR_OK;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= '0;
            end
          end else if (cnt_q == CNT_LAST) begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= '0;
            resp_err_q   <= ERR_TO;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_WAIT: begin
          // Data arriving in the last allowed cycle still wins over the timeout.
          if (rdata_valid_in) begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= load_d;
            resp_err_q   <= ERR_OK;
          end else if (cnt_q == CNT_LAST) begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= '0;
            resp_err_q   <= ERR_TO;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RESP: begin
          state_q      <= S_IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
          resp_rdata_q <= '0;
          resp_err_q   <= ERR_OK;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready_out         = req_ready_q;
  assign valid_out             = valid_q;
  assign ram_read_en_out       = rd_en_q;
  assign ram_write_en_out      = wr_en_q;
  assign ram_write_byte_en_out = be_q;
  assign ram_addr_out          = ram_addr_q;
  assign ram_write_data_out    = wdata_q;
  assign resp_valid_out        = resp_valid_q;
  assign resp_rdata_out        = resp_rdata_q;
  assign resp_err_out          = resp_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized and directed checks of mem_access_unit against a cycle-count reference model.
module tb_mem_access_unit;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid_in = 1'b0;
  logic        req_ready_out;
  logic        req_is_store_in = 1'b0;
  logic [2:0]  req_funct3_in = 3'd0;
  logic [31:0] req_addr_in = 32'd0;
  logic [31:0] req_wdata_in = 32'd0;
  logic [31:0] ram_addr_out;
  logic [31:0] ram_write_data_out;
  logic        ram_read_en_out;
  logic        ram_write_en_out;
  logic [3:0]  ram_write_byte_en_out;
  logic        valid_out;
  logic        ready_in = 1'b0;
  logic        rdata_valid_in = 1'b0;
  logic [31:0] ram_read_data_in = 32'd0;
  logic        resp_valid_out;
  logic [31:0] resp_rdata_out;
  logic [1:0]  resp_err_out;

  int n_tests = 0;
  int n_fail  = 0;

  mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
    .req_is_store_in(req_is_store_in), .req_funct3_in(req_funct3_in),
    .req_addr_in(req_addr_in), .req_wdata_in(req_wdata_in),
    .ram_addr_out(ram_addr_out), .ram_write_data_out(ram_write_data_out),
    .ram_read_en_out(ram_read_en_out), .ram_write_en_out(ram_write_en_out),
    .ram_write_byte_en_out(ram_write_byte_en_out), .valid_out(valid_out),
    .ready_in(ready_in), .rdata_valid_in(rdata_valid_in),
    .ram_read_data_in(ram_read_data_in), .resp_valid_out(resp_valid_out),
    .resp_rdata_out(resp_rdata_out), .resp_err_out(resp_err_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          resp_cyc;
    int          npulse;
    logic [1:0]  err;
    logic [31:0] rdata;
    int          nvalid;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rd;
    logic        wr;
    bit          unstable;
    bit          ready_bad;
  } obs_t;

  // Expected outcome from the access rules: cycle 0 is the accept cycle.
  function automatic obs_t model(bit st, logic [2:0] f3, logic [31:0] addr, logic [31:0] wd,
                                 logic [31:0] rd, int d, int lat, bit hold);
    obs_t e;
    int o, sz, hs;
    logic [31:0] v, m;
    e.npulse = 1; e.err = 2'd0; e.rdata = 0; e.nvalid = 0; e.unstable = 0; e.ready_bad = 0;
    e.addr = addr & 32'hFFFF_FFFC;
    o  = int'(addr % 4);
    sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    e.rd = !st; e.wr = st;
    e.be = st ? 4'(((1 << sz) - 1) << o) : 4'hF;
    for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = wd[8*(i % sz) +: 8];
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 || (o % sz) != 0) begin
      e.err = 2'd1; e.resp_cyc = 1; e.nvalid = 0;
      return e;
    end
    if (hold) d = 0;
    if (d >= TO) begin
      e.err = 2'd2; e.nvalid = TO; e.resp_cyc = 1 + TO;
      return e;
    end
    e.nvalid = d + 1;
    hs = 1 + d;
    if (st || lat == 0) e.resp_cyc = hs + 1;
    else if (lat <= TO) e.resp_cyc = hs + 1 + lat;
    else begin
      e.resp_cyc = hs + 1 + TO; e.err = 2'd2;
    end
    if (!st && e.err == 2'd0) begin
      m = (sz == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * sz)) - 32'd1;
      v = (rd >> (8 * o)) & m;
      if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~m;
      e.rdata = v;
    end
    return e;
  endfunction

  // Drives one request and plays the ram: ready after d valid cycles (or held), read data lat cycles after handshake.
  task automatic do_txn(input bit st, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rd, input int d, input int lat, input bit hold, output obs_t ob);
    int c, vcnt, hs;
    ob.resp_cyc = -1; ob.npulse = 0; ob.err = 2'd3; ob.rdata = 32'hDEAD_BEEF; ob.nvalid = 0;
    ob.addr = 0; ob.be = 0; ob.wdata = 0; ob.rd = 0; ob.wr = 0; ob.unstable = 0; ob.ready_bad = 0;
    @(negedge clk);
    if (req_ready_out !== 1'b1) ob.ready_bad = 1;
    req_valid_in = 1; req_is_store_in = st; req_funct3_in = f3; req_addr_in = addr; req_wdata_in = wd;
    ready_in = hold; rdata_valid_in = 0; ram_read_data_in = $urandom;
    c = 0; vcnt = 0; hs = -1;
    while (c < 30 && !(ob.resp_cyc >= 0 && c >= ob.resp_cyc + 2)) begin
      @(negedge clk);
      c++;
      req_valid_in = 0;
      if (resp_valid_out === 1'b1) begin
        ob.npulse++;
        if (ob.resp_cyc < 0) begin
          ob.resp_cyc = c; ob.err = resp_err_out; ob.rdata = resp_rdata_out;
        end
      end
      if (req_ready_out !== ((ob.resp_cyc >= 0 && c > ob.resp_cyc) ? 1'b1 : 1'b0)) ob.ready_bad = 1;
      if (valid_out === 1'b1) begin
        vcnt++;
        if (vcnt == 1) begin
          ob.addr = ram_addr_out; ob.be = ram_write_byte_en_out; ob.wdata = ram_write_data_out;
          ob.rd = ram_read_en_out; ob.wr = ram_write_en_out;
        end else if (ob.addr !== ram_addr_out || ob.be !== ram_write_byte_en_out ||
                     ob.wdata !== ram_write_data_out || ob.rd !== ram_read_en_out ||
                     ob.wr !== ram_write_en_out) ob.unstable = 1;
        if (!hold) ready_in = (vcnt == d + 1);
        if (hs < 0 && (hold || vcnt == d + 1)) hs = c;
      end else begin
        if (!hold) ready_in = 0;
        if (ram_read_en_out !== 1'b0 || ram_write_en_out !== 1'b0 || ram_write_byte_en_out !== 4'd0)
          ob.unstable = 1;
      end
      rdata_valid_in = (hs >= 0 && !st && c == hs + lat);
      ram_read_data_in = rdata_valid_in ? rd : $urandom;
    end
    ob.nvalid = vcnt;
    ready_in = 0; rdata_valid_in = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({valid_out, ram_read_en_out, ram_write_en_out, ram_write_byte_en_out, ram_addr_out,
         ram_write_data_out, resp_valid_out, resp_rdata_out, resp_err_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got valid=%b be=%b addr=%h resp=%b err=%b want all 0",
               valid_out, ram_write_byte_en_out, ram_addr_out, resp_valid_out, resp_err_out);
    end
    rst = 0;
    @(negedge clk);
    n_tests++;
    if (req_ready_out !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready got %b want 1", req_ready_out);
    end
  endtask

  task automatic test_store_word();
    obs_t ob;
    do_txn(1, 3'b010, 32'h08, 32'hFFFF_0000, 0, 0, 0, 1, ob);
    n_tests++; if (ob.nvalid !== 1) begin n_fail++; $display("FAIL sw_nvalid got %0d want 1", ob.nvalid); end
    n_tests++; if (ob.addr !== 32'h08) begin n_fail++; $display("FAIL sw_addr got %h want 00000008", ob.addr); end
    n_tests++; if (ob.be !== 4'b1111 || ob.wr !== 1'b1) begin n_fail++; $display("FAIL sw_be got %b wr=%b want 1111 wr=1", ob.be, ob.wr); end
    n_tests++; if (ob.wdata !== 32'hFFFF_0000) begin n_fail++; $display("FAIL sw_data got %h want ffff0000", ob.wdata); end
    n_tests++; if (ob.resp_cyc !== 2 || ob.err !== 2'b00) begin n_fail++; $display("FAIL sw_resp got cyc=%0d err=%b want cyc=2 err=00", ob.resp_cyc, ob.err); end
  endtask

  task automatic test_store_byte();
    obs_t ob;
    do_txn(1, 3'b000, 32'h0B, 32'h0000_00A5, 0, 0, 0, 0, ob);
    n_tests++; if (ob.addr !== 32'h08) begin n_fail++; $display("FAIL sb_addr got %h want 00000008", ob.addr); end
    n_tests++; if (ob.be !== 4'b1000) begin n_fail++; $display("FAIL sb_be got %b want 1000", ob.be); end
    n_tests++; if (ob.wdata !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL sb_data got %h want a5a5a5a5", ob.wdata); end
  endtask

  task automatic test_loads();
    obs_t ob;
    do_txn(0, 3'b000, 32'h09, 0, 32'h0000_8000, 0, 1, 0, ob);
    n_tests++; if (ob.rdata !== 32'hFFFF_FF80 || ob.resp_cyc !== 3) begin n_fail++; $display("FAIL lb_data got %h cyc=%0d want ffffff80 cyc=3", ob.rdata, ob.resp_cyc); end
    n_tests++; if (ob.rd !== 1'b1 || ob.be !== 4'b1111) begin n_fail++; $display("FAIL lb_req got rd=%b be=%b want rd=1 be=1111", ob.rd, ob.be); end
    do_txn(0, 3'b100, 32'h09, 0, 32'h0000_8000, 0, 1, 0, ob);
    n_tests++; if (ob.rdata !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_data got %h want 00000080", ob.rdata); end
    do_txn(0, 3'b101, 32'h0A, 0, 32'hBEEF_0000, 0, 1, 0, ob);
    n_tests++; if (ob.rdata !== 32'h0000_BEEF) begin n_fail++; $display("FAIL lhu_data got %h want 0000beef", ob.rdata); end
    do_txn(0, 3'b010, 32'h10, 0, 32'h1234_5678, 0, 0, 0, ob);
    n_tests++; if (ob.rdata !== 32'h1234_5678 || ob.resp_cyc !== 2) begin n_fail++; $display("FAIL lw_same_cycle got %h cyc=%0d want 12345678 cyc=2", ob.rdata, ob.resp_cyc); end
  endtask

  task automatic test_misaligned();
    obs_t ob;
    do_txn(0, 3'b010, 32'h06, 0, 0, 0, 1, 0, ob);
    n_tests++; if (ob.nvalid !== 0) begin n_fail++; $display("FAIL lw_mis_valid got %0d want 0", ob.nvalid); end
    n_tests++; if (ob.err !== 2'b01 || ob.resp_cyc !== 1) begin n_fail++; $display("FAIL lw_mis_resp got err=%b cyc=%0d want err=01 cyc=1", ob.err, ob.resp_cyc); end
    do_txn(1, 3'b001, 32'h03, 32'h1234, 0, 0, 0, 0, ob);
    n_tests++; if (ob.err !== 2'b01 || ob.nvalid !== 0) begin n_fail++; $display("FAIL sh_mis got err=%b nvalid=%0d want err=01 nvalid=0", ob.err, ob.nvalid); end
    do_txn(0, 3'b011, 32'h00, 0, 0, 0, 1, 0, ob);
    n_tests++; if (ob.err !== 2'b01) begin n_fail++; $display("FAIL funct3_011 got err=%b want 01", ob.err); end
  endtask

  task automatic test_timeout();
    obs_t ob;
    do_txn(1, 3'b010, 32'h20, 32'h5555_AAAA, 0, 99, 0, 0, ob);
    n_tests++; if (ob.nvalid !== TO) begin n_fail++; $display("FAIL to_nvalid got %0d want %0d", ob.nvalid, TO); end
    n_tests++; if (ob.err !== 2'b10 || ob.resp_cyc !== TO + 1 || ob.rdata !== 0) begin n_fail++; $display("FAIL to_resp got err=%b cyc=%0d rdata=%h want err=10 cyc=%0d rdata=0", ob.err, ob.resp_cyc, ob.rdata, TO + 1); end
    do_txn(0, 3'b010, 32'h24, 0, 32'hCAFE_F00D, 0, 1, 0, ob);
    n_tests++; if (ob.err !== 2'b00 || ob.rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL to_recover got err=%b rdata=%h want err=00 rdata=cafef00d", ob.err, ob.rdata); end
    do_txn(0, 3'b010, 32'h28, 0, 32'h1111_2222, 0, 6, 0, ob);
    n_tests++; if (ob.err !== 2'b10 || ob.resp_cyc !== TO + 2 || ob.npulse !== 1) begin n_fail++; $display("FAIL wait_to got err=%b cyc=%0d pulses=%0d want err=10 cyc=%0d pulses=1", ob.err, ob.resp_cyc, ob.npulse, TO + 2); end
  endtask

  task automatic test_reset_abort();
    int pulses = 0;
    @(negedge clk);
    req_valid_in = 1; req_is_store_in = 0; req_funct3_in = 3'b010; req_addr_in = 32'h40; ready_in = 1;
    @(negedge clk);
    req_valid_in = 0;
    @(negedge clk);
    n_tests++; if (valid_out !== 1'b0 || req_ready_out !== 1'b0) begin n_fail++; $display("FAIL abort_in_wait got valid=%b ready=%b want 0 0", valid_out, req_ready_out); end
    rst = 1; ready_in = 0;
    @(negedge clk);
    rst = 0;
    n_tests++; if ({valid_out, ram_read_en_out, ram_write_en_out, ram_write_byte_en_out, ram_addr_out, resp_valid_out, resp_err_out} !== '0) begin n_fail++; $display("FAIL abort_outputs got valid=%b rd=%b addr=%h resp=%b want all 0", valid_out, ram_read_en_out, ram_addr_out, resp_valid_out); end
    @(negedge clk);
    n_tests++; if (req_ready_out !== 1'b1) begin n_fail++; $display("FAIL abort_ready got %b want 1", req_ready_out); end
    rdata_valid_in = 1; ready_in = 1; ram_read_data_in = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (resp_valid_out !== 1'b0) pulses++;
      rdata_valid_in = 0; ready_in = 0;
    end
    n_tests++; if (pulses !== 0) begin n_fail++; $display("FAIL stray_rdata got %0d responses want 0", pulses); end
  endtask

  task automatic test_random();
    obs_t ob, e;
    bit st, hold;
    logic [2:0] f3;
    logic [31:0] addr, wd, rd;
    int d, lat;
    logic [2:0] ltab [6] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3};
    for (int i = 0; i < 60; i++) begin
      st   = 1'($urandom_range(0, 1));
      f3   = st ? 3'($urandom_range(0, 2)) : ltab[$urandom_range(0, 5)];
      addr = $urandom; wd = $urandom; rd = $urandom;
      if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
      d    = ($urandom_range(0, 7) == 0) ? 5 : int'($urandom_range(0, 3));
      lat  = ($urandom_range(0, 7) == 0) ? 6 : int'($urandom_range(0, 4));
      hold = ($urandom_range(0, 3) == 0);
      e = model(st, f3, addr, wd, rd, d, lat, hold);
      do_txn(st, f3, addr, wd, rd, d, lat, hold, ob);
      n_tests++; if (ob.resp_cyc !== e.resp_cyc || ob.npulse !== 1) begin n_fail++; $display("FAIL rnd%0d_timing got cyc=%0d pulses=%0d want cyc=%0d pulses=1", i, ob.resp_cyc, ob.npulse, e.resp_cyc); end
      n_tests++; if (ob.err !== e.err) begin n_fail++; $display("FAIL rnd%0d_err got %b want %b", i, ob.err, e.err); end
      n_tests++; if (ob.rdata !== e.rdata) begin n_fail++; $display("FAIL rnd%0d_rdata got %h want %h", i, ob.rdata, e.rdata); end
      n_tests++; if (ob.nvalid !== e.nvalid) begin n_fail++; $display("FAIL rnd%0d_nvalid got %0d want %0d", i, ob.nvalid, e.nvalid); end
      n_tests++; if (ob.unstable || ob.ready_bad) begin n_fail++; $display("FAIL rnd%0d_handshake got unstable=%0d ready_bad=%0d want 0 0", i, ob.unstable, ob.ready_bad); end
      if (e.nvalid > 0) begin
        n_tests++; if (ob.addr !== e.addr || ob.be !== e.be) begin n_fail++; $display("FAIL rnd%0d_addr_be got %h/%b want %h/%b", i, ob.addr, ob.be, e.addr, e.be); end
        n_tests++; if (ob.rd !== e.rd || ob.wr !== e.wr) begin n_fail++; $display("FAIL rnd%0d_en got rd=%b wr=%b want rd=%b wr=%b", i, ob.rd, ob.wr, e.rd, e.wr); end
        if (st) begin
          n_tests++; if (ob.wdata !== e.wdata) begin n_fail++; $display("FAIL rnd%0d_wdata got %h want %h", i, ob.wdata, e.wdata); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_store_byte();
    test_loads();
    test_misaligned();
    test_timeout();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
